// File: rtl/commit_unit_pkg.sv
// Shared types for the reorder-buffer commit path.
// Holds the buffer geometry, entry layout, execution state, functional unit,
// load/store width and the commit FSM state encoding.
package commit_unit_pkg;

  localparam int unsigned BUF_SIZE_LOG = 4;
  localparam int unsigned BUF_SIZE     = 2 ** BUF_SIZE_LOG;
  localparam int unsigned TAG_W        = BUF_SIZE_LOG + 1;
  localparam int unsigned XLEN         = 32;
  localparam int unsigned REG_W        = 5;

  typedef enum logic [2:0] {
    S_EMPTY,
    S_ISSUED,
    S_ADDR_GENERATED,
    S_EXECUTING,
    S_EXECUTED
  } state_t;

  typedef enum logic [1:0] {
    U_ALU,
    U_BRANCH,
    U_LOAD,
    U_STORE
  } unit_t;

  typedef enum logic [1:0] {
    LDST_BYTE,
    LDST_HALF,
    LDST_WORD
  } ldst_mode_t;

  // One reorder-buffer slot as seen by the commit unit.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    state_t           e_state;
    unit_t            unit;
    logic [REG_W-1:0] dest;
    logic [XLEN-1:0]  result;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  vk;
    ldst_mode_t       rwmm;
  } entry_t;

  typedef enum logic {
    C_IDLE,
    C_STORE_REQ
  } commit_state_t;

endpackage

// File: rtl/commit_unit_tag_finder.sv
// tag_finder: combinational search of the reorder buffer for one tag.
// Ports:
//   entries - current buffer contents
//   tag     - tag to look for
//   hit     - some non-empty entry carries the tag
//   idx     - index of the matching entry (lowest index on duplicates)
//   ready   - the matching entry is in S_EXECUTED
module tag_finder
  import commit_unit_pkg::*;
#(
  parameter int unsigned BUF_SIZE_LOG = commit_unit_pkg::BUF_SIZE_LOG
) (
  input  entry_t                  entries [2**BUF_SIZE_LOG],
  input  logic [BUF_SIZE_LOG:0]   tag,
  output logic                    hit,
  output logic [BUF_SIZE_LOG-1:0] idx,
  output logic                    ready
);

  localparam int unsigned DEPTH = 2 ** BUF_SIZE_LOG;

  // Scan from the top down so the lowest matching index is the one kept.
  always_comb begin
    hit   = 1'b0;
    idx   = '0;
    ready = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (entries[i].e_state != S_EMPTY && entries[i].tag == TAG_W'(tag)) begin
        hit   = 1'b1;
        idx   = BUF_SIZE_LOG'(i);
        ready = (entries[i].e_state == S_EXECUTED);
      end
    end
  end

endmodule

// File: rtl/commit_unit.sv
// commit_unit: in-order retirement from the reorder buffer.
// Retires the head entry (slot 0) and, when COMMIT_DUAL_EN is defined, the
// entry after it (slot 1) in the same cycle. Stores go through a memory
// handshake before they retire.
// Ports:
//   clk, reset            - clock, synchronous active-low reset
//   entries               - current buffer contents
//   mem_ready             - data memory accepted the store this cycle
//   is_really_commited    - per-slot one-cycle commit pulse
//   is_commited_store     - committed slot was a store
//   commited_tags         - tag retired per slot
//   rf_we/rf_addr/rf_data - per-slot register-file write
//   mem_req/mem_addr/mem_wdata/mem_mode - store request to data memory
//   head_tag              - tag of the oldest uncommitted instruction
// Build option: COMMIT_DUAL_EN enables the second commit slot.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int unsigned BUF_SIZE_LOG = commit_unit_pkg::BUF_SIZE_LOG
) (
  input  logic                  clk,
  input  logic                  reset,
  input  entry_t                entries [2**BUF_SIZE_LOG],
  input  logic                  mem_ready,
  output logic [1:0]            is_really_commited,
  output logic [1:0]            is_commited_store,
  output logic [BUF_SIZE_LOG:0] commited_tags [2],
  output logic [1:0]            rf_we,
  output logic [4:0]            rf_addr [2],
  output logic [31:0]           rf_data [2],
  output logic                  mem_req,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output ldst_mode_t            mem_mode,
  output logic [BUF_SIZE_LOG:0] head_tag
);

  localparam int unsigned DEPTH = 2 ** BUF_SIZE_LOG;
  localparam int unsigned TW    = BUF_SIZE_LOG + 1;

  // Tags run 1 .. 2*DEPTH-1 and wrap back to 1; tag 0 is reserved.
  function automatic logic [BUF_SIZE_LOG:0] next_tag(input logic [BUF_SIZE_LOG:0] t);
    return (t == TW'(2 * DEPTH - 1)) ? TW'(1) : t + TW'(1);
  endfunction

  commit_state_t           state;
  logic                    hit0;
  logic                    rdy0;
  logic [BUF_SIZE_LOG-1:0] idx0;
  logic                    take0;
  logic                    start_store;

  tag_finder #(.BUF_SIZE_LOG(BUF_SIZE_LOG)) u_find0 (
    .entries (entries),
    .tag     (head_tag),
    .hit     (hit0),
    .idx     (idx0),
    .ready   (rdy0)
  );

`ifdef COMMIT_DUAL_EN
  logic                    hit1;
  logic                    rdy1;
  logic [BUF_SIZE_LOG-1:0] idx1;
  logic [BUF_SIZE_LOG:0]   slot1_tag;
  logic                    take1;

  assign slot1_tag = next_tag(head_tag);

  tag_finder #(.BUF_SIZE_LOG(BUF_SIZE_LOG)) u_find1 (
    .entries (entries),
    .tag     (slot1_tag),
    .hit     (hit1),
    .idx     (idx1),
    .ready   (rdy1)
  );
`endif

  // Commit decisions for the current cycle.
  always_comb begin
    take0       = 1'b0;
    start_store = 1'b0;
    if (state == C_IDLE && hit0 && rdy0) begin
      if (entries[idx0].unit == U_STORE) start_store = 1'b1;
      else                               take0       = 1'b1;
    end
`ifdef COMMIT_DUAL_EN
    // Slot 1 rides along only behind a non-store slot 0 and never retires
    // stores or branches itself.
    take1 = take0 && hit1 && rdy1 &&
            entries[idx1].unit != U_STORE && entries[idx1].unit != U_BRANCH;
`endif
  end

  // Commit FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state              <= C_IDLE;
      head_tag           <= TW'(1);
      is_really_commited <= '0;
      is_commited_store  <= '0;
      rf_we              <= '0;
      for (int k = 0; k < 2; k++) begin
        commited_tags[k] <= '0;
        rf_addr[k]       <= '0;
        rf_data[k]       <= '0;
      end
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_mode  <= LDST_BYTE;
    end else begin
      is_really_commited <= '0;
      is_commited_store  <= '0;
      rf_we              <= '0;
      for (int k = 0; k < 2; k++) begin
        commited_tags[k] <= '0;
        rf_addr[k]       <= '0;
        rf_data[k]       <= '0;
      end
      case (state)
        C_IDLE: begin
          if (start_store) begin
            // Latch the store so the request stays stable while waiting.
            state     <= C_STORE_REQ;
            mem_req   <= 1'b1;
            mem_addr  <= entries[idx0].a;
            mem_wdata <= entries[idx0].vk;
            mem_mode  <= entries[idx0].rwmm;
          end else if (take0) begin
            is_really_commited[0] <= 1'b1;
            commited_tags[0]      <= head_tag;
            rf_we[0]              <= (entries[idx0].dest != '0);
            rf_addr[0]            <= entries[idx0].dest;
            rf_data[0]            <= entries[idx0].result;
            head_tag              <= next_tag(head_tag);
`ifdef COMMIT_DUAL_EN
            if (take1) begin
              is_really_commited[1] <= 1'b1;
              commited_tags[1]      <= slot1_tag;
              rf_we[1]              <= (entries[idx1].dest != '0);
              rf_addr[1]            <= entries[idx1].dest;
              rf_data[1]            <= entries[idx1].result;
              head_tag              <= next_tag(slot1_tag);
            end
`endif
          end
        end
        C_STORE_REQ: begin
          if (mem_ready) begin
            state                 <= C_IDLE;
            mem_req               <= 1'b0;
            mem_addr              <= '0;
            mem_wdata             <= '0;
            mem_mode              <= LDST_BYTE;
            is_really_commited[0] <= 1'b1;
            is_commited_store[0]  <= 1'b1;
            commited_tags[0]      <= head_tag;
            head_tag              <= next_tag(head_tag);
          end
        end
        default: state <= C_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit with a commit scoreboard.
module tb_commit_unit;
  import commit_unit_pkg::*;

  typedef struct {
    logic        slot;
    logic [4:0]  tag;
    logic        store;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  entry_t      entries [BUF_SIZE];
  logic        mem_ready;
  logic [1:0]  is_really_commited;
  logic [1:0]  is_commited_store;
  logic [4:0]  commited_tags [2];
  logic [1:0]  rf_we;
  logic [4:0]  rf_addr [2];
  logic [31:0] rf_data [2];
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  ldst_mode_t  mem_mode;
  logic [4:0]  head_tag;

  int   checks;
  int   passed;
  exp_t sb [$];

  commit_unit #(.BUF_SIZE_LOG(BUF_SIZE_LOG)) dut (
    .clk                (clk),
    .reset              (reset),
    .entries            (entries),
    .mem_ready          (mem_ready),
    .is_really_commited (is_really_commited),
    .is_commited_store  (is_commited_store),
    .commited_tags      (commited_tags),
    .rf_we              (rf_we),
    .rf_addr            (rf_addr),
    .rf_data            (rf_data),
    .mem_req            (mem_req),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_mode           (mem_mode),
    .head_tag           (head_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks = checks + 1;
    assert (obs === expv) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int idx, input logic [4:0] tag, input state_t st, input unit_t u,
                     input logic [4:0] dest, input logic [31:0] res, input logic [31:0] a,
                     input logic [31:0] vk, input ldst_mode_t m);
    entries[idx].tag     = tag;
    entries[idx].e_state = st;
    entries[idx].unit    = u;
    entries[idx].dest    = dest;
    entries[idx].result  = res;
    entries[idx].a       = a;
    entries[idx].vk      = vk;
    entries[idx].rwmm    = m;
  endtask

  task automatic clear_buf();
    for (int i = 0; i < int'(BUF_SIZE); i++) put(i, 0, S_EMPTY, U_ALU, 0, 0, 0, 0, LDST_BYTE);
  endtask

  task automatic exp_c(input logic slot, input logic [4:0] tag, input logic store, input logic we,
                       input logic [4:0] addr, input logic [31:0] data);
    exp_t e;
    e.slot = slot; e.tag = tag; e.store = store; e.we = we; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  // Scoreboard: every commit pulse must match the oldest expected retirement.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (is_really_commited[k]) begin
        chk("sb_pending", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_slot", 64'(k), 64'(e.slot));
          chk("sb_tag", 64'(commited_tags[k]), 64'(e.tag));
          chk("sb_store", 64'(is_commited_store[k]), 64'(e.store));
          chk("sb_we", 64'(rf_we[k]), 64'(e.we));
          if (e.we) begin
            chk("sb_addr", 64'(rf_addr[k]), 64'(e.addr));
            chk("sb_data", 64'(rf_data[k]), 64'(e.data));
          end
        end
      end else begin
        chk("idle_we", 64'(rf_we[k]), 0);
      end
    end
  end

  initial begin
    checks    = 0;
    passed    = 0;
    reset     = 1'b0;
    mem_ready = 1'b0;
    clear_buf();
    tick(); tick();
    chk("rst_head", 64'(head_tag), 1);
    chk("rst_commit", 64'(is_really_commited), 0);
    chk("rst_memreq", 64'(mem_req), 0);
    chk("rst_mode", 64'(mem_mode), 64'(LDST_BYTE));
    reset = 1'b1;
    tick();
    chk("empty_head", 64'(head_tag), 1);
    chk("empty_commit", 64'(is_really_commited), 0);

    // Single ALU commit.
    put(3, 1, S_EXECUTED, U_ALU, 5, 32'h1234, 0, 0, LDST_WORD);
    exp_c(0, 1, 0, 1, 5, 32'h1234);
    tick();
    chk("alu_pulse", 64'(is_really_commited), 2'b01);
    chk("alu_tag", 64'(commited_tags[0]), 1);
    chk("alu_we", 64'(rf_we), 2'b01);
    chk("alu_addr", 64'(rf_addr[0]), 5);
    chk("alu_data", 64'(rf_data[0]), 32'h1234);
    chk("alu_head", 64'(head_tag), 2);
    clear_buf();
    tick();
    chk("alu_once", 64'(is_really_commited), 0);

    // Two ALU entries back to back; second has Dest 0.
    put(0, 2, S_EXECUTED, U_ALU, 7, 32'h22, 0, 0, LDST_WORD);
    put(1, 3, S_EXECUTED, U_ALU, 0, 32'h33, 0, 0, LDST_WORD);
`ifdef COMMIT_DUAL_EN
    exp_c(0, 2, 0, 1, 7, 32'h22);
    exp_c(1, 3, 0, 0, 0, 32'h33);
    tick();
    chk("dual_pulse", 64'(is_really_commited), 2'b11);
    chk("dual_head", 64'(head_tag), 4);
`else
    exp_c(0, 2, 0, 1, 7, 32'h22);
    exp_c(0, 3, 0, 0, 0, 32'h33);
    tick();
    chk("seq_pulse_a", 64'(is_really_commited), 2'b01);
    chk("seq_head_a", 64'(head_tag), 3);
    tick();
    chk("seq_pulse_b", 64'(is_really_commited), 2'b01);
    chk("seq_head_b", 64'(head_tag), 4);
`endif
    clear_buf();
    tick();

    // Store with three cycles of back-pressure; executed ALU behind it waits.
    put(5, 4, S_EXECUTED, U_STORE, 9, 0, 32'h100, 32'hAB, LDST_BYTE);
    put(6, 5, S_EXECUTED, U_ALU, 10, 32'h55, 0, 0, LDST_WORD);
    exp_c(0, 4, 1, 0, 0, 0);
    exp_c(0, 5, 0, 1, 10, 32'h55);
    tick();
    for (int c = 0; c < 4; c++) begin
      chk("st_req", 64'(mem_req), 1);
      chk("st_addr", 64'(mem_addr), 32'h100);
      chk("st_wdata", 64'(mem_wdata), 32'hAB);
      chk("st_mode", 64'(mem_mode), 64'(LDST_BYTE));
      chk("st_nocommit", 64'(is_really_commited), 0);
      chk("st_head", 64'(head_tag), 4);
      if (c < 3) tick();
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("st_req_drop", 64'(mem_req), 0);
    chk("st_pulse", 64'(is_really_commited), 2'b01);
    chk("st_flag", 64'(is_commited_store), 2'b01);
    chk("st_we", 64'(rf_we), 0);
    chk("st_head_adv", 64'(head_tag), 5);
    put(5, 0, S_EMPTY, U_ALU, 0, 0, 0, 0, LDST_BYTE);
    tick();
    chk("after_st_tag", 64'(commited_tags[0]), 5);
    chk("after_st_head", 64'(head_tag), 6);
    clear_buf();
    tick();

    // Head not yet executed blocks an executed younger entry.
    put(2, 6, S_ADDR_GENERATED, U_LOAD, 11, 32'h66, 0, 0, LDST_WORD);
    put(4, 7, S_EXECUTED, U_ALU, 12, 32'h77, 0, 0, LDST_WORD);
    tick();
    chk("blk_addr_gen", 64'(is_really_commited), 0);
    tick();
    chk("blk_head", 64'(head_tag), 6);
    put(2, 6, S_EXECUTING, U_LOAD, 11, 32'h66, 0, 0, LDST_WORD);
    tick();
    chk("blk_executing", 64'(is_really_commited), 0);
    chk("blk_head2", 64'(head_tag), 6);
    put(2, 6, S_EXECUTED, U_LOAD, 11, 32'h66, 0, 0, LDST_WORD);
`ifdef COMMIT_DUAL_EN
    exp_c(0, 6, 0, 1, 11, 32'h66);
    exp_c(1, 7, 0, 1, 12, 32'h77);
    tick();
    chk("unblk_pulse", 64'(is_really_commited), 2'b11);
`else
    exp_c(0, 6, 0, 1, 11, 32'h66);
    exp_c(0, 7, 0, 1, 12, 32'h77);
    tick();
    chk("unblk_pulse", 64'(is_really_commited), 2'b01);
    tick();
`endif
    chk("unblk_head", 64'(head_tag), 8);
    clear_buf();
    tick();

    // Branch behind an ALU only retires from slot 0, with a link write.
    put(0, 8, S_EXECUTED, U_ALU, 1, 32'h88, 0, 0, LDST_WORD);
    put(1, 9, S_EXECUTED, U_BRANCH, 31, 32'h40, 0, 0, LDST_WORD);
    exp_c(0, 8, 0, 1, 1, 32'h88);
    exp_c(0, 9, 0, 1, 31, 32'h40);
    tick();
    chk("br_first", 64'(is_really_commited), 2'b01);
    chk("br_head_a", 64'(head_tag), 9);
    tick();
    chk("br_slot0", 64'(is_really_commited), 2'b01);
    chk("br_link_addr", 64'(rf_addr[0]), 31);
    chk("br_head_b", 64'(head_tag), 10);
    clear_buf();
    tick();

    // Duplicate tag: lowest index supplies the data.
    put(9, 10, S_EXECUTED, U_ALU, 3, 32'hBBBB, 0, 0, LDST_WORD);
    put(2, 10, S_EXECUTED, U_ALU, 2, 32'hAAAA, 0, 0, LDST_WORD);
    exp_c(0, 10, 0, 1, 2, 32'hAAAA);
    tick();
    chk("dup_data", 64'(rf_data[0]), 32'hAAAA);
    chk("dup_head", 64'(head_tag), 11);
    clear_buf();

    // Walk the head up to the last tag before wrap.
    for (int t = 11; t <= 30; t++) begin
      put(t % 16, 5'(t), S_EXECUTED, U_ALU, 5'(t), 32'(t), 0, 0, LDST_WORD);
      exp_c(0, 5'(t), 0, 1, 5'(t), 32'(t));
      tick();
      chk("walk_head", 64'(head_tag), 64'(t + 1));
      clear_buf();
    end

    // Tag wrap 31 -> 1.
    put(7, 31, S_EXECUTED, U_ALU, 13, 32'h31, 0, 0, LDST_WORD);
    put(8, 1, S_EXECUTED, U_ALU, 14, 32'h01, 0, 0, LDST_WORD);
`ifdef COMMIT_DUAL_EN
    exp_c(0, 31, 0, 1, 13, 32'h31);
    exp_c(1, 1, 0, 1, 14, 32'h01);
    tick();
    chk("wrap_pulse", 64'(is_really_commited), 2'b11);
    chk("wrap_tag1", 64'(commited_tags[1]), 1);
`else
    exp_c(0, 31, 0, 1, 13, 32'h31);
    exp_c(0, 1, 0, 1, 14, 32'h01);
    tick();
    chk("wrap_head_mid", 64'(head_tag), 1);
    tick();
    chk("wrap_tag0", 64'(commited_tags[0]), 1);
`endif
    chk("wrap_head", 64'(head_tag), 2);
    clear_buf();
    tick();

    // Reset while a store is pending abandons it.
    put(0, 2, S_EXECUTED, U_STORE, 0, 0, 32'h200, 32'hCD, LDST_WORD);
    tick();
    chk("rs_req", 64'(mem_req), 1);
    tick();
    chk("rs_req_hold", 64'(mem_req), 1);
    reset = 1'b0;
    tick();
    chk("rs_req_drop", 64'(mem_req), 0);
    chk("rs_nocommit", 64'(is_really_commited), 0);
    chk("rs_head", 64'(head_tag), 1);
    clear_buf();
    reset = 1'b1;
    tick();
    chk("rs_after_req", 64'(mem_req), 0);
    chk("rs_after_commit", 64'(is_really_commited), 0);
    chk("rs_after_head", 64'(head_tag), 1);
    tick();

    chk("sb_drained", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
